// File: rtl/morse_keyer_pkg.sv
// Shared symbol encoding, word geometry and gap lengths for the Morse lookup and keyer stages.
package morse_keyer_pkg;

  localparam int SYM_W  = 3;
  localparam int SYMS   = 8;
  localparam int WORD_W = SYM_W * SYMS;

  localparam logic [2:0] DOT  = 3'b010;
  localparam logic [2:0] DASH = 3'b011;
  localparam logic [2:0] LAST = 3'b100;

  localparam logic [2:0] ELEM_GAP   = 3'd1;
  localparam logic [2:0] CHAR_GAP   = 3'd3;
  localparam logic [2:0] WORD_EXTRA = 3'd4;
  localparam logic [2:0] DASH_UNITS = 3'd3;
  localparam logic [2:0] DOT_UNITS  = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYM,
    ST_MARK,
    ST_GAP
  } state_t;

  function automatic logic is_mark(input logic [2:0] s);
    return (s[1:0] == DOT[1:0]) || (s[1:0] == DASH[1:0]);
  endfunction

  function automatic logic is_last(input logic [2:0] s);
    return (s & LAST) != 3'b000;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Counts whole dit units; done is high in the final clock of a 'units'-long interval.
module morse_unit_timer #(
  parameter int UNIT_CYCLES = 3_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] units,
  output logic       done
);

  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);

  logic [CW-1:0] cyc_cnt;
  logic [2:0]    unit_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt  <= '0;
      unit_cnt <= '0;
    end else if (start) begin
      cyc_cnt  <= '0;
      unit_cnt <= '0;
    end else if (cyc_cnt == CYC_LAST) begin
      cyc_cnt <= '0;
      if (unit_cnt != 3'd6) unit_cnt <= unit_cnt + 3'd1;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

  assign done = (cyc_cnt == CYC_LAST) && (unit_cnt == units - 3'd1);

endmodule

// File: rtl/morse_keyer.sv
// Plays packed Morse words as a timed key signal with standard element/char/word spacing.
// Optional sidetone output is built when MORSE_SIDETONE_EN is defined.
module morse_keyer
  import morse_keyer_pkg::*;
#(
  parameter int UNIT_CYCLES = 3_000_000,
  parameter int TONE_DIV    = 25_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_morse,
  output logic              in_ready,
  output logic              key_out,
`ifdef MORSE_SIDETONE_EN
  output logic              busy,
  output logic              tone_out
`else
  output logic              busy
`endif
);

  state_t            state;
  logic [WORD_W-1:0] word_q;
  logic [2:0]        idx;
  logic [2:0]        units_q;
  logic              last_q;
  logic              done;
  logic              timer_start;
  logic [SYM_W-1:0]  sym;

  // The current symbol is always the top field; the word shifts left as symbols are consumed.
  assign sym         = word_q[WORD_W-1 -: SYM_W];
  assign timer_start = !((state == ST_MARK) || (state == ST_GAP)) || done;
  assign busy        = ~in_ready;

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (timer_start),
    .units (units_q),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      word_q   <= '0;
      idx      <= '0;
      units_q  <= '0;
      last_q   <= 1'b0;
      key_out  <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            word_q   <= in_morse;
            idx      <= '0;
            last_q   <= 1'b0;
            in_ready <= 1'b0;
            state    <= ST_SYM;
          end
        end
        ST_SYM: begin
          if (is_mark(sym)) begin
            key_out <= 1'b1;
            units_q <= sym[0] ? DASH_UNITS : DOT_UNITS;
            state   <= ST_MARK;
          end else if (is_last(sym) || idx == 3'd7) begin
            // A lone LAST marker in slot 0 is a word space; otherwise it just closes the character.
            units_q <= (is_last(sym) && idx == 3'd0) ? WORD_EXTRA : CHAR_GAP;
            last_q  <= 1'b1;
            state   <= ST_GAP;
          end else begin
            idx    <= idx + 3'd1;
            word_q <= word_q << SYM_W;
          end
        end
        ST_MARK: begin
          if (done) begin
            key_out <= 1'b0;
            state   <= ST_GAP;
            if (is_last(sym) || idx == 3'd7) begin
              units_q <= CHAR_GAP;
              last_q  <= 1'b1;
            end else begin
              units_q <= ELEM_GAP;
              idx     <= idx + 3'd1;
              word_q  <= word_q << SYM_W;
            end
          end
        end
        ST_GAP: begin
          if (done) begin
            if (last_q) begin
              last_q   <= 1'b0;
              in_ready <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              state <= ST_SYM;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MORSE_SIDETONE_EN
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

  logic [TW-1:0] tone_cnt;
  logic          tone_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (!key_out) begin
      tone_cnt <= '0;
      tone_q   <= 1'b0;
    end else if (tone_cnt == TONE_LAST) begin
      tone_cnt <= '0;
      tone_q   <= ~tone_q;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

  assign tone_out = tone_q & key_out;
`else
  wire unused_tone_div = |TONE_DIV;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer with UNIT_CYCLES=4, TONE_DIV=2; samples on the falling edge.
`timescale 1ns/1ps
module tb_morse_keyer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_morse = '0;
  logic        in_ready;
  logic        key_out;
  logic        busy;
`ifdef MORSE_SIDETONE_EN
  logic        tone_out;
`endif

  int checks = 0;
  int fails  = 0;
  int accepts = 0;

  localparam logic [23:0] W_E     = 24'hC00000;
  localparam logic [23:0] W_T     = 24'hE00000;
  localparam logic [23:0] W_A     = 24'h5C0000;
  localparam logic [23:0] W_SPACE = 24'h100000;
  localparam logic [23:0] W_WORD  = 24'h800000;
  localparam logic [23:0] W_ERR   = 24'h492492;
  localparam logic [23:0] W_ZERO  = 24'h6DBE00;

  morse_keyer #(.UNIT_CYCLES(4), .TONE_DIV(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_morse (in_morse),
    .in_ready (in_ready),
    .key_out  (key_out),
`ifdef MORSE_SIDETONE_EN
    .busy     (busy),
    .tone_out (tone_out)
`else
    .busy     (busy)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && in_valid && in_ready) accepts++;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Counts consecutive falling-edge samples at the given key level (bounded).
  task automatic run_len(input logic level, input int limit, output int n);
    n = 0;
    while (key_out === level && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic ready_wait(input int limit, output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_accept(input int a0, output logic ok);
    int n;
    n = 0;
    while (accepts == a0 && n < 60) begin
      n++;
      @(negedge clk);
    end
    ok = (accepts != a0);
  endtask

  // Presents a word and drops valid once it is taken; returns on the first SYM-cycle sample.
  task automatic send(input logic [23:0] w, input string name);
    logic ok;
    int a0;
    a0 = accepts;
    in_valid = 1'b1;
    in_morse = w;
    wait_accept(a0, ok);
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_accept: got 0 expected 1", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (key_out !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got key=%b ready=%b busy=%b expected 0 1 0", key_out, in_ready, busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (key_out !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got key=%b ready=%b busy=%b expected 0 1 0", key_out, in_ready, busy);
    end
  endtask

  task automatic test_letter_e();
    int n, a0;
    a0 = accepts;
    send(W_E, "e");
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL e_busy: got %b expected 1", busy);
    end
    run_len(1'b0, 40, n); expect_val("e_sym_low", n, 1);
    run_len(1'b1, 40, n); expect_val("e_mark", n, 4);
    ready_wait(60, n);    expect_val("e_tail", n, 12);
    repeat (4) @(negedge clk);
    expect_val("e_one_handshake", accepts - a0, 1);
    expect_val("e_key_idle", int'(key_out), 0);
  endtask

  task automatic test_letter_a();
    int n;
    send(W_A, "a");
    run_len(1'b0, 40, n); expect_val("a_sym_low", n, 1);
    run_len(1'b1, 40, n); expect_val("a_dot", n, 4);
    run_len(1'b0, 40, n); expect_val("a_elem_gap", n, 5);
    run_len(1'b1, 40, n); expect_val("a_dash", n, 12);
    ready_wait(60, n);    expect_val("a_tail", n, 12);
  endtask

  // Space word (skip, then LAST at slot 1) followed by T with valid held throughout.
  task automatic test_space_then_t();
    int n, a0;
    logic ok;
    a0 = accepts;
    in_valid = 1'b1;
    in_morse = W_SPACE;
    wait_accept(a0, ok);
    in_morse = W_T;
    run_len(1'b0, 60, n); expect_val("space_t_silence", n, 16);
    in_valid = 1'b0;
    run_len(1'b1, 40, n); expect_val("space_t_mark", n, 12);
    ready_wait(60, n);    expect_val("space_t_tail", n, 12);
    expect_val("space_t_accepts", accepts - a0, 2);
  endtask

  task automatic test_word_space();
    int n;
    send(W_WORD, "word");
    ready_wait(60, n); expect_val("word_gap_busy", n, 17);
    expect_val("word_gap_key", int'(key_out), 0);
  endtask

  task automatic test_error_code();
    int n;
    int bad_mark, bad_gap;
    bad_mark = 0;
    bad_gap  = 0;
    send(W_ERR, "err");
    run_len(1'b0, 40, n); expect_val("err_sym_low", n, 1);
    for (int i = 0; i < 8; i++) begin
      run_len(1'b1, 40, n);
      if (n != 4) bad_mark++;
      if (i < 7) begin
        run_len(1'b0, 40, n);
        if (n != 5) bad_gap++;
      end
    end
    expect_val("err_marks_4clk", bad_mark, 0);
    expect_val("err_gaps_5clk", bad_gap, 0);
    ready_wait(60, n); expect_val("err_tail", n, 12);
  endtask

  task automatic test_reset_mid_word();
    int n, residue;
    send(W_ZERO, "zero");
    run_len(1'b0, 40, n); expect_val("zero_sym_low", n, 1);
    run_len(1'b1, 40, n); expect_val("zero_dash1", n, 12);
    run_len(1'b0, 40, n); expect_val("zero_gap1", n, 5);
    @(negedge clk);
    expect_val("zero_mid_dash_key", int'(key_out), 1);
    rst_n = 1'b0;
    #1;
    expect_val("zero_async_key", int'(key_out), 0);
    expect_val("zero_async_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    residue = 0;
    repeat (40) begin
      @(negedge clk);
      if (key_out !== 1'b0 || in_ready !== 1'b1) residue++;
    end
    expect_val("zero_no_residue", residue, 0);
    send(W_E, "zero_after");
    run_len(1'b0, 40, n);
    run_len(1'b1, 40, n); expect_val("zero_after_mark", n, 4);
    ready_wait(60, n);
  endtask

  task automatic test_back_to_back();
    int n, a0;
    logic ok;
    a0 = accepts;
    in_valid = 1'b1;
    in_morse = W_E;
    wait_accept(a0, ok);
    in_morse = W_T;
    run_len(1'b0, 40, n); expect_val("b2b_sym_low", n, 1);
    run_len(1'b1, 40, n); expect_val("b2b_e_mark", n, 4);
    run_len(1'b0, 40, n); expect_val("b2b_between", n, 14);
    in_valid = 1'b0;
    run_len(1'b1, 40, n); expect_val("b2b_t_mark", n, 12);
    ready_wait(60, n);    expect_val("b2b_tail", n, 12);
    expect_val("b2b_accepts", accepts - a0, 2);
  endtask

`ifdef MORSE_SIDETONE_EN
  task automatic test_sidetone();
    int n;
    logic [3:0] seen;
    send(W_E, "tone");
    run_len(1'b0, 40, n);
    for (int i = 3; i >= 0; i--) begin
      seen[i] = tone_out;
      @(negedge clk);
    end
    expect_val("tone_pattern", int'(seen), 4'b0011);
    expect_val("tone_off_in_gap", int'(tone_out), 0);
    ready_wait(60, n);
  endtask
`endif

  initial begin
    test_reset();
    test_letter_e();
    test_letter_a();
    test_space_then_t();
    test_word_space();
    test_error_code();
    test_reset_mid_word();
    test_back_to_back();
`ifdef MORSE_SIDETONE_EN
    test_sidetone();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
